// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Sequential PC generator feeding a 1-cycle-latency synchronous
//            instruction memory, with a FIFO of {PC, instruction} pairs that
//            drives decode over a valid/ready handshake. A redirect flushes
//            all buffered and in-flight fetches.
// Ports    : clock, reset            - clock, synchronous active-high reset
//            next_PC_select, target_PC - redirect strobe and target
//            PC                      - next address to fetch (registered)
//            imem_req/imem_addr/imem_rdata - instruction memory read port
//            out_valid/out_ready/out_PC/out_instruction - decode handshake
//            count                   - number of buffered entries
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int                        ADDRESS_BITS = 16,
    parameter int                        DATA_WIDTH   = 32,
    parameter logic [ADDRESS_BITS-1:0]   RESET_PC     = '0,
    parameter int                        PC_STEP      = 4,
    parameter int                        FIFO_DEPTH   = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              next_PC_select,
    input  logic [ADDRESS_BITS-1:0]           target_PC,
    output logic [ADDRESS_BITS-1:0]           PC,
    output logic                              imem_req,
    output logic [ADDRESS_BITS-1:0]           imem_addr,
    input  logic [DATA_WIDTH-1:0]             imem_rdata,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ADDRESS_BITS-1:0]           out_PC,
    output logic [DATA_WIDTH-1:0]             out_instruction,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam int c_PW = $clog2(FIFO_DEPTH);

    logic [ADDRESS_BITS-1:0] r_pc;
    logic                    r_inflight;
    logic [ADDRESS_BITS-1:0] r_inflight_pc;
    logic [c_CW-1:0]         r_count;
    logic [c_PW-1:0]         r_wr_ptr;
    logic [c_PW-1:0]         r_rd_ptr;
    logic [ADDRESS_BITS-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   r_fifo_instr [FIFO_DEPTH];

    logic [c_CW:0]           w_occupancy;
    logic                    w_credit;
    logic                    w_push;
    logic                    w_pop;

    // Outstanding request counts as occupied so the response always has a
    // slot; a pop in this cycle is deliberately not credited.
    assign w_occupancy = {1'b0, r_count} + {{c_CW{1'b0}}, r_inflight};
    assign w_credit    = w_occupancy < (c_CW+1)'(FIFO_DEPTH);

    assign imem_req  = !reset && !next_PC_select && w_credit;
    assign imem_addr = r_pc;
    assign PC        = r_pc;

    assign out_valid       = (r_count != '0) && !next_PC_select && !reset;
    assign out_PC          = r_fifo_pc[r_rd_ptr];
    assign out_instruction = r_fifo_instr[r_rd_ptr];
    assign count           = r_count;

    // out_valid already masks reset/redirect, so no pop happens then.
    assign w_pop  = out_valid && out_ready;
    assign w_push = r_inflight;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else if (next_PC_select) begin
            // Flush: the pending response is simply never pushed.
            r_pc       <= target_PC;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_pc          <= r_pc + ADDRESS_BITS'(PC_STEP);
                r_inflight_pc <= r_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clock) begin
        if (!reset && !next_PC_select && w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire
